// File: rtl/activation_sequencer.sv
// activation_sequencer: job-driven controller that streams accumulator/target words through the
// activation pipeline and writes the int8 results to the UB. Define ACT_SEQ_LOSS_EN to add loss_sum.
module activation_sequencer #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_W-1:0]        cmd_src_addr,
  input  logic [ADDR_W-1:0]        cmd_dst_addr,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     cmd_passthrough,
  input  logic                     cmd_unsigned,
  input  logic signed [15:0]       cmd_norm_gain,
  input  logic signed [31:0]       cmd_norm_bias,
  input  logic [4:0]               cmd_norm_shift,
  input  logic signed [15:0]       cmd_q_inv_scale,
  input  logic signed [7:0]        cmd_q_zero_point,
  output logic                     cfg_passthrough,
  output logic                     cfg_unsigned,
  output logic signed [15:0]       cfg_norm_gain,
  output logic signed [31:0]       cfg_norm_bias,
  output logic [4:0]               cfg_norm_shift,
  output logic signed [15:0]       cfg_q_inv_scale,
  output logic signed [7:0]        cfg_q_zero_point,
  output logic                     acc_rd_en,
  output logic [ADDR_W-1:0]        acc_rd_addr,
  input  logic [31:0]              acc_rd_data,
  input  logic [31:0]              tgt_rd_data,
  output logic                     pipe_valid_in,
  output logic [31:0]              pipe_acc_in,
  output logic [31:0]              pipe_target_in,
  input  logic                     pipe_valid_out,
  input  logic [7:0]               pipe_data,
  input  logic                     pipe_loss_valid,
  input  logic signed [31:0]       pipe_loss,
  output logic                     ub_wr_en,
  output logic [ADDR_W-1:0]        ub_wr_addr,
  output logic [7:0]               ub_wr_data,
  input  logic                     ub_wr_ready,
`ifdef ACT_SEQ_LOSS_EN
  output logic signed [47:0]       loss_sum,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CRD_W = PTR_W + 1;
  localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  src_q, dst_q;
  logic [LEN_W-1:0]   len_q, issued, written, issued_inc;
  logic [CRD_W-1:0]   credits;
  logic [PTR_W:0]     rd_ptr, wr_ptr;
  logic [7:0]         mem [FIFO_DEPTH];
  logic               pvi_q;
  logic               cmd_fire, rd_fire, push, pop, fifo_empty, fifo_full;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign issued_inc = issued + LEN_ONE;
  assign rd_fire    = (state == RUN) && (issued != len_q) && (credits != '0);
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_full  = (rd_ptr[PTR_W] != wr_ptr[PTR_W]) &&
                      (rd_ptr[PTR_W-1:0] == wr_ptr[PTR_W-1:0]);
  // Results arriving while idle belong to no job and are discarded.
  assign push       = pipe_valid_out && (state != IDLE);
  assign pop        = !fifo_empty && ub_wr_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_fire) state_nxt = RUN;
      RUN:     if ((issued == len_q) || (rd_fire && (issued_inc == len_q))) state_nxt = DRAIN;
      DRAIN:   if (written == len_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = (state == IDLE) && !rst;
    busy           = (state != IDLE);
    done           = (state == DRAIN) && (written == len_q);
    acc_rd_en      = rd_fire;
    acc_rd_addr    = src_q + ADDR_W'(issued);
    pipe_valid_in  = pvi_q;
    pipe_acc_in    = pvi_q ? acc_rd_data : '0;
    pipe_target_in = pvi_q ? tgt_rd_data : '0;
    ub_wr_en       = !fifo_empty;
    ub_wr_addr     = dst_q + ADDR_W'(written);
    ub_wr_data     = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q            <= '0;
      dst_q            <= '0;
      len_q            <= '0;
      issued           <= '0;
      written          <= '0;
      credits          <= CRD_FULL;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      pvi_q            <= 1'b0;
      err              <= 1'b0;
      cfg_passthrough  <= 1'b0;
      cfg_unsigned     <= 1'b0;
      cfg_norm_gain    <= '0;
      cfg_norm_bias    <= '0;
      cfg_norm_shift   <= '0;
      cfg_q_inv_scale  <= '0;
      cfg_q_zero_point <= '0;
    end else begin
      pvi_q <= rd_fire;
      if (cmd_fire) begin
        src_q            <= cmd_src_addr;
        dst_q            <= cmd_dst_addr;
        len_q            <= cmd_len;
        issued           <= '0;
        written          <= '0;
        cfg_passthrough  <= cmd_passthrough;
        cfg_unsigned     <= cmd_unsigned;
        cfg_norm_gain    <= cmd_norm_gain;
        cfg_norm_bias    <= cmd_norm_bias;
        cfg_norm_shift   <= cmd_norm_shift;
        cfg_q_inv_scale  <= cmd_q_inv_scale;
        cfg_q_zero_point <= cmd_q_zero_point;
      end else begin
        if (rd_fire) issued  <= issued_inc;
        if (pop)     written <= written + LEN_ONE;
      end
      // One credit per word between read issue and UB acceptance.
      if (rd_fire && !pop)      credits <= credits - CRD_ONE;
      else if (pop && !rd_fire) credits <= credits + CRD_ONE;
      if (push) begin
        if (fifo_full) err    <= 1'b1;
        else           wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !fifo_full) mem[wr_ptr[PTR_W-1:0]] <= pipe_data;
  end

`ifdef ACT_SEQ_LOSS_EN
  always_ff @(posedge clk) begin
    if (rst)                         loss_sum <= '0;
    else if (cmd_fire)               loss_sum <= '0;
    else if (pipe_loss_valid && busy) loss_sum <= loss_sum + {{16{pipe_loss[31]}}, pipe_loss};
  end
`else
  logic unused_loss;
  assign unused_loss = ^{pipe_loss_valid, pipe_loss};
`endif

endmodule
